lcd_text_feeder: RTL and testbench
==================================

Name: lcd_text_feeder

Overview:
- Upstream stage of the LCD driver: turns a byte-wide ASCII character stream into the driver's 32-bit 4-character words and command writes.
- Packs characters MSB-first, tracks cursor line/column, and inserts DDRAM line-address commands at line wrap.
- Pads partial words and lines with PAD_CHAR.
- Runs the driver's enableWriting/LCD_Available handshake, so top levels no longer hand-sequence strings.

Parameters:
- LINE_CHARS, 16, characters per display line; must be a multiple of 4.
- LINES, 2, display lines, 1 or 2.
- START_TIMEOUT, 1024, cycles allowed for lcd_available to fall after an issue.
- PAD_CHAR, 8'h20, fill character for padding.
- LINE1_ADDR, 8'h80, set-DDRAM command for line 0.
- LINE2_ADDR, 8'hC0, set-DDRAM command for line 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- char_data  in  8  ASCII character
- char_valid  in  1  char_data valid
- char_ready  out  1  feeder accepts a character this cycle
- flush  in  1  pad the current partial word and send it
- lcd_data  out  32  to driver data; character 0 in [31:24]
- lcd_select_cd  out  1  1 = data write, 0 = command write
- lcd_enable_writing  out  1  one-cycle write strobe to the driver
- lcd_available  in  1  driver idle / ready
- busy  out  1  word or command in flight, or padding in progress
- timeout_err  out  1  sticky; set when lcd_available fails to fall in time
- cursor_col  out  4  current column (0..LINE_CHARS-1)
- cursor_line  out  1  current line

Behaviour:
- Reset values:
  - lcd_data = 0, lcd_select_cd = 1, lcd_enable_writing = 0.
  - busy = 0, timeout_err = 0, cursor = 0/0, byte count = 0.
- States: ACCUM, PAD, ISSUE, WAIT_START, WAIT_DONE, plus CMD_ISSUE/CMD_WAIT_START/CMD_WAIT_DONE, or one shared handshake path tagged data/command.
- char_ready = (state == ACCUM) and the word is not full. A character is taken when char_valid & char_ready.
- Packing:
  - Byte k (0..3) of a word goes to lcd_data[31-8k -: 8].
  - Byte 3 accepted → go to ISSUE on the next cycle.
- Newline (8'h0A):
  - Consumed without being stored.
  - If column and byte count are both 0, it is ignored.
  - Otherwise → PAD: inserts PAD_CHAR one per cycle until the line end, sending each full word.
- flush:
  - Sampled in ACCUM.
  - With a nonempty word → PAD to the word boundary only, then send.
  - With an empty word → ignored.
  - A same-cycle character is accepted first; if that fills the word, the flush is dropped.
- ISSUE:
  - Wait for lcd_available = 1, then assert lcd_enable_writing for exactly 1 cycle.
  - lcd_data and lcd_select_cd stay stable from ISSUE through the exit of WAIT_DONE.
- WAIT_START:
  - Wait for lcd_available = 0 (driver started).
  - If the counter reaches START_TIMEOUT, set timeout_err and treat the write as complete.
- WAIT_DONE: wait for lcd_available = 1, then the write is complete.
- After a data word completes:
  - col += 4.
  - If col == LINE_CHARS: col = 0, line = (line+1) mod LINES, then issue a command with lcd_select_cd = 0 and lcd_data = {24'h0, LINE1_ADDR or LINE2_ADDR of the new line}.
  - Then return to ACCUM with an empty word.
- Wrap from the last line goes to line 0 (LINE1_ADDR); it overwrites and does not clear.
- busy = (state != ACCUM).
- Reset mid-operation (async): the strobe drops at once, the partial word and any pending command are discarded, and the cursor returns to 0/0.

Optional Feature:
- Macro: LCD_FEEDER_CLEAR_ON_RESET_EN.
- Defined: after reset, issue command 8'h01 (clear), then LINE1_ADDR, before entering ACCUM. char_ready = 0 and busy = 1 until both commands complete.
- Undefined: start directly in ACCUM with char_ready = 1, relying on the driver's own init to leave the cursor at line 0, column 0.

Decomposition:
- Package lcd_feeder_pkg:
  - state enum.
  - CMD_CLEAR = 8'h01, ASCII_NL = 8'h0A, ASCII_SPACE = 8'h20.
  - Default line addresses.
- Sub-module lcd_write_handshake (ISSUE/WAIT_START/WAIT_DONE and the timeout counter):
  - Inputs: start, word, select.
  - Outputs: done, timeout pulse, driver strobe.
  - The feeder instantiates it once for both data and command writes.

Test Plan:
- "HELLO WORLD!" streamed back-to-back, driver model busy 3 cycles:
  - Words 0x48454C4C, 0x4F20574F, 0x524C4421, each with one strobe and select = 1.
  - No command; cursor_col = 12.
- 16 chars "A".."P":
  - 4 data words, then a command with lcd_data = 0x000000C0, select = 0; cursor = line 1, col 0.
  - 16 more chars → command 0x00000080, cursor = 0/0.
- "HI", then newline → 0x48492020, then 3× 0x20202020, then the 0xC0 command. A second newline at col 0 produces no write.
- "AB", then flush → single word 0x41422020, cursor_col = 4. Flush with an empty word → no strobe.
- lcd_available tied to 1 → timeout_err = 1 after START_TIMEOUT cycles, and the next word still issues.
- rst pulsed during WAIT_DONE:
  - Strobe = 0 and lcd_data = 0 immediately.
  - Next "X" after reset is packed as byte 0 at col 0.

Source files
------------

// File: rtl/lcd_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_feeder_pkg
// Brief    : Shared types, constants and helpers for the LCD text feeder.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_feeder_pkg;

    localparam logic [7:0] CMD_CLEAR       = 8'h01;
    localparam logic [7:0] ASCII_NL        = 8'h0A;
    localparam logic [7:0] ASCII_SPACE     = 8'h20;
    localparam logic [7:0] DEF_LINE1_ADDR  = 8'h80;
    localparam logic [7:0] DEF_LINE2_ADDR  = 8'hC0;

    // Feeder sequencing; the actual driver handshake lives in lcd_write_handshake
    typedef enum logic [2:0] {
        FS_ACCUM = 3'd0,
        FS_PAD   = 3'd1,
        FS_ISSUE = 3'd2,
        FS_WAIT  = 3'd3,
        FS_INIT  = 3'd4
    } feeder_state_t;

    typedef enum logic [1:0] {
        HS_IDLE       = 2'd0,
        HS_ISSUE      = 2'd1,
        HS_WAIT_START = 2'd2,
        HS_WAIT_DONE  = 2'd3
    } hs_state_t;

    // Byte idx 0 lands in [31:24], idx 3 in [7:0]
    function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  ch);
        logic [31:0] v_word;
        v_word = word;
        case (idx)
            2'd0:    v_word[31:24] = ch;
            2'd1:    v_word[23:16] = ch;
            2'd2:    v_word[15:8]  = ch;
            default: v_word[7:0]   = ch;
        endcase
        return v_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_text_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_feeder_if
// Brief    : Character stream in, LCD driver write bus out.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_text_feeder_if;

    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic        flush;
    logic [31:0] lcd_data;
    logic        lcd_select_cd;
    logic        lcd_enable_writing;
    logic        lcd_available;

    modport master (
        output char_data, char_valid, flush, lcd_available,
        input  char_ready, lcd_data, lcd_select_cd, lcd_enable_writing
    );

    modport slave (
        input  char_data, char_valid, flush, lcd_available,
        output char_ready, lcd_data, lcd_select_cd, lcd_enable_writing
    );

endinterface
`default_nettype wire

// File: rtl/lcd_write_handshake.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_handshake
// Brief    : One enableWriting/LCD_Available transaction with start timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_write_handshake
    import lcd_feeder_pkg::*;
#(
    parameter int START_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] word,
    input  logic        select,
    input  logic        lcd_available,
    output logic        done,
    output logic        timeout,
    output logic        lcd_enable_writing,
    output logic [31:0] lcd_data,
    output logic        lcd_select_cd
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    hs_state_t          r_state;
    hs_state_t          w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_strobe;
    logic [31:0]        r_data;
    logic               r_sel;

    always_comb begin
        w_next  = r_state;
        done    = 1'b0;
        timeout = 1'b0;
        case (r_state)
            HS_IDLE:       if (start) w_next = HS_ISSUE;
            HS_ISSUE:      if (lcd_available) w_next = HS_WAIT_START;
            HS_WAIT_START: begin
                if (!lcd_available) begin
                    w_next = HS_WAIT_DONE;
                end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    // Driver never acknowledged; give up so the stream keeps moving
                    timeout = 1'b1;
                    done    = 1'b1;
                    w_next  = HS_IDLE;
                end
            end
            HS_WAIT_DONE: begin
                if (lcd_available) begin
                    done   = 1'b1;
                    w_next = HS_IDLE;
                end
            end
            default:       w_next = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= HS_IDLE;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
            r_data   <= 32'h0;
            r_sel    <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_strobe <= (r_state == HS_ISSUE) && lcd_available;
            r_cnt    <= (r_state == HS_WAIT_START) ? r_cnt + CNT_W'(1) : '0;
            if ((r_state == HS_IDLE) && start) begin
                r_data <= word;
                r_sel  <= select;
            end
        end
    end

    assign lcd_enable_writing = r_strobe;
    assign lcd_data           = r_data;
    assign lcd_select_cd      = r_sel;

endmodule
`default_nettype wire

// File: rtl/lcd_text_feeder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_feeder
// Brief    : Packs an ASCII stream into 4-char LCD words with line wrapping.
//            LCD_FEEDER_CLEAR_ON_RESET_EN: clear + home the display after reset.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_text_feeder
    import lcd_feeder_pkg::*;
#(
    parameter int         LINE_CHARS    = 16,
    parameter int         LINES         = 2,
    parameter int         START_TIMEOUT = 1024,
    parameter logic [7:0] PAD_CHAR      = ASCII_SPACE,
    parameter logic [7:0] LINE1_ADDR    = DEF_LINE1_ADDR,
    parameter logic [7:0] LINE2_ADDR    = DEF_LINE2_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    lcd_text_feeder_if.slave    bus,
    output logic                busy,
    output logic                timeout_err,
    output logic [3:0]          cursor_col,
    output logic                cursor_line
);

`ifdef LCD_FEEDER_CLEAR_ON_RESET_EN
    localparam feeder_state_t RESET_STATE = FS_INIT;
`else
    localparam feeder_state_t RESET_STATE = FS_ACCUM;
`endif

    feeder_state_t  r_state, w_next;
    logic [31:0]    r_word, w_word;
    logic [1:0]     r_cnt, w_cnt;
    logic [3:0]     r_col, w_col;
    logic           r_line, w_line;
    logic           r_is_cmd, w_is_cmd;
    logic           r_pad_line, w_pad_line;
    logic           r_home_pending, w_home_pending;
    logic           r_timeout_err;
    logic           w_start;
    logic           w_hs_done;
    logic           w_hs_timeout;
    logic [4:0]     w_col_inc;

    lcd_write_handshake #(
        .START_TIMEOUT (START_TIMEOUT)
    ) u_handshake (
        .clk                (clk),
        .rst                (rst),
        .start              (w_start),
        .word               (r_word),
        .select             (~r_is_cmd),
        .lcd_available      (bus.lcd_available),
        .done               (w_hs_done),
        .timeout            (w_hs_timeout),
        .lcd_enable_writing (bus.lcd_enable_writing),
        .lcd_data           (bus.lcd_data),
        .lcd_select_cd      (bus.lcd_select_cd)
    );

    assign w_col_inc = {1'b0, r_col} + 5'd4;

    always_comb begin
        w_next         = r_state;
        w_word         = r_word;
        w_cnt          = r_cnt;
        w_col          = r_col;
        w_line         = r_line;
        w_is_cmd       = r_is_cmd;
        w_pad_line     = r_pad_line;
        w_home_pending = r_home_pending;
        w_start        = 1'b0;
        case (r_state)
            FS_ACCUM: begin
                if (bus.char_valid) begin
                    if (bus.char_data == ASCII_NL) begin
                        // A newline on an empty line start would only emit a blank line
                        if ((r_col != 4'd0) || (r_cnt != 2'd0)) begin
                            w_pad_line = 1'b1;
                            w_next     = FS_PAD;
                        end
                    end else begin
                        w_word = pack_byte(r_word, r_cnt, bus.char_data);
                        if (r_cnt == 2'd3) begin
                            w_cnt  = 2'd0;
                            w_next = FS_ISSUE;
                        end else begin
                            w_cnt = r_cnt + 2'd1;
                            if (bus.flush) begin
                                w_pad_line = 1'b0;
                                w_next     = FS_PAD;
                            end
                        end
                    end
                end else if (bus.flush && (r_cnt != 2'd0)) begin
                    w_pad_line = 1'b0;
                    w_next     = FS_PAD;
                end
            end
            FS_PAD: begin
                w_word = pack_byte(r_word, r_cnt, PAD_CHAR);
                if (r_cnt == 2'd3) begin
                    w_cnt  = 2'd0;
                    w_next = FS_ISSUE;
                end else begin
                    w_cnt = r_cnt + 2'd1;
                end
            end
            FS_ISSUE: begin
                w_start = 1'b1;
                w_next  = FS_WAIT;
            end
            FS_WAIT: begin
                if (w_hs_done) begin
                    if (!r_is_cmd) begin
                        if (w_col_inc == 5'(LINE_CHARS)) begin
                            w_col    = 4'd0;
                            w_line   = (LINES > 1) ? ~r_line : 1'b0;
                            w_word   = {24'h0, (w_line ? LINE2_ADDR : LINE1_ADDR)};
                            w_is_cmd = 1'b1;
                            w_next   = FS_ISSUE;
                        end else begin
                            w_col  = r_col + 4'd4;
                            w_next = r_pad_line ? FS_PAD : FS_ACCUM;
                        end
                    end else if (r_home_pending) begin
                        w_home_pending = 1'b0;
                        w_word         = {24'h0, LINE1_ADDR};
                        w_next         = FS_ISSUE;
                    end else begin
                        w_is_cmd   = 1'b0;
                        w_pad_line = 1'b0;
                        w_next     = FS_ACCUM;
                    end
                end
            end
            FS_INIT: begin
                w_word         = {24'h0, CMD_CLEAR};
                w_is_cmd       = 1'b1;
                w_home_pending = 1'b1;
                w_next         = FS_ISSUE;
            end
            default: w_next = FS_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= RESET_STATE;
            r_word         <= 32'h0;
            r_cnt          <= 2'd0;
            r_col          <= 4'd0;
            r_line         <= 1'b0;
            r_is_cmd       <= 1'b0;
            r_pad_line     <= 1'b0;
            r_home_pending <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_word         <= w_word;
            r_cnt          <= w_cnt;
            r_col          <= w_col;
            r_line         <= w_line;
            r_is_cmd       <= w_is_cmd;
            r_pad_line     <= w_pad_line;
            r_home_pending <= w_home_pending;
            if (w_hs_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign bus.char_ready = (r_state == FS_ACCUM);
    assign busy           = (r_state != FS_ACCUM);
    assign timeout_err    = r_timeout_err;
    assign cursor_col     = r_col;
    assign cursor_line    = r_line;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_text_feeder
// Brief    : Randomised bench with a queue-based text/cursor reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_text_feeder;

    localparam int LINE_CHARS = 16;
    localparam int LINES      = 2;
    localparam int TO         = 64;

    typedef struct packed {
        logic [31:0] data;
        logic        sel;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, timeout_err, cursor_line;
    logic [3:0] cursor_col;

    always #5 clk = ~clk;

    lcd_text_feeder_if bus();

    lcd_text_feeder #(
        .LINE_CHARS    (LINE_CHARS),
        .LINES         (LINES),
        .START_TIMEOUT (TO),
        .PAD_CHAR      (8'h20),
        .LINE1_ADDR    (8'h80),
        .LINE2_ADDR    (8'hC0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err),
        .cursor_col  (cursor_col),
        .cursor_line (cursor_line)
    );

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;
    bit tie_high = 1'b0;
    int drv_min  = 1;
    int drv_max  = 4;

    // Reference model: text layout in terms of a column count and a byte queue
    int          m_col  = 0;
    int          m_line = 0;
    logic [7:0]  m_buf[$];
    wr_t         exp_q[$];
    wr_t         hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void emit(input logic [31:0] d, input logic s);
        wr_t w;
        w.data = d;
        w.sel  = s;
        exp_q.push_back(w);
        hist.push_back(w);
    endfunction

    function automatic void emit_word();
        logic [31:0] w;
        w = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
        m_buf.delete();
        emit(w, 1'b1);
        m_col += 4;
        if (m_col == LINE_CHARS) begin
            m_col  = 0;
            m_line = (m_line + 1) % LINES;
            emit({24'h0, (m_line == 1) ? 8'hC0 : 8'h80}, 1'b0);
        end
    endfunction

    function automatic void model_char(input logic [7:0] c);
        if (c == 8'h0A) begin
            if (m_col != 0 || m_buf.size() != 0) begin
                do begin
                    m_buf.push_back(8'h20);
                    if (m_buf.size() == 4) emit_word();
                end while (m_col != 0 || m_buf.size() != 0);
            end
        end else begin
            m_buf.push_back(c);
            if (m_buf.size() == 4) emit_word();
        end
    endfunction

    function automatic void model_flush();
        if (m_buf.size() != 0) begin
            while (m_buf.size() < 4) m_buf.push_back(8'h20);
            emit_word();
        end
    endfunction

    function automatic void model_reset();
        m_col  = 0;
        m_line = 0;
        m_buf.delete();
        exp_q.delete();
    endfunction

    // Driver model: goes busy for a few cycles after each strobe
    initial begin
        bus.lcd_available = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.lcd_enable_writing && !tie_high) begin
                bus.lcd_available = 1'b0;
                repeat ($urandom_range(drv_max, drv_min)) @(negedge clk);
                bus.lcd_available = 1'b1;
            end
        end
    end

    // Compare process: every strobe against the model, every cycle for status
    initial begin
        bit  prev = 1'b0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("busy_vs_ready", busy, !bus.char_ready);
                if (bus.lcd_enable_writing) begin
                    strobes++;
                    chk("strobe_width", prev, 1'b0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=%h sel=%b required=no_write",
                                 bus.lcd_data, bus.lcd_select_cd);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_data", bus.lcd_data, e.data);
                        chk("write_sel", bus.lcd_select_cd, e.sel);
                    end
                end
                prev = bus.lcd_enable_writing;
            end else begin
                prev = 1'b0;
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL %s_ready_timeout actual=0 required=1", name);
        end
    endtask

    task automatic send(input logic [7:0] c, input bit fl);
        @(negedge clk);
        bus.char_valid = 1'b1;
        bus.char_data  = c;
        bus.flush      = fl;
        wait_ready("send");
        @(posedge clk);
        model_char(c);
        if (fl) model_flush();
        #1;
        bus.char_valid = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic send_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        wait_ready("flush");
        @(posedge clk);
        model_flush();
        #1;
        bus.flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0 || !bus.lcd_available) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            failures++;
            $display("FAIL %s_idle_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.lcd_enable_writing && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL %s_strobe_timeout actual=0 required=1", name);
        end
    endtask

    task automatic check_cursor(input string name);
        chk({name, "_col"}, cursor_col, m_col);
        chk({name, "_line"}, cursor_line, m_line);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string s;
        int    h0;
        int    s0;
        int    n;
        int    r;
        logic [7:0] c;

        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        bus.flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lcd_data", bus.lcd_data, 32'h0);
        chk("rst_select", bus.lcd_select_cd, 1'b1);
        chk("rst_strobe", bus.lcd_enable_writing, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_col", cursor_col, 4'd0);
        chk("rst_line", cursor_line, 1'b0);
        chk("rst_ready", bus.char_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // HELLO WORLD! with a fixed 3-cycle driver
        drv_min = 3;
        drv_max = 3;
        s  = "HELLO WORLD!";
        h0 = hist.size();
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
        wait_idle("hello");
        chk("hello_writes", hist.size() - h0, 3);
        chk("hello_w0", hist[h0].data, 32'h48454C4C);
        chk("hello_w1", hist[h0+1].data, 32'h4F20574F);
        chk("hello_w2", hist[h0+2].data, 32'h524C4421);
        chk("hello_col", cursor_col, 4'd12);
        check_cursor("hello");

        // Full line A..P wraps to line 1, then another 16 wrap back to line 0
        drv_min = 1;
        drv_max = 4;
        do_reset();
        h0 = hist.size();
        for (int i = 0; i < 16; i++) send(8'h41 + 8'(i), 1'b0);
        wait_idle("line0");
        chk("line0_first", hist[h0].data, 32'h41424344);
        chk("line0_cmd", {hist[h0+4].data[30:0], hist[h0+4].sel}, {31'h000000C0, 1'b0});
        chk("line0_line", cursor_line, 1'b1);
        chk("line0_col", cursor_col, 4'd0);
        h0 = hist.size();
        for (int i = 0; i < 16; i++) send(8'($urandom_range(126, 33)), 1'b0);
        wait_idle("line1");
        chk("line1_cmd", {hist[h0+4].data[30:0], hist[h0+4].sel}, {31'h00000080, 1'b0});
        chk("line1_line", cursor_line, 1'b0);
        check_cursor("line1");

        // Newline pads the rest of the line; a newline at column 0 is silent
        do_reset();
        h0 = hist.size();
        send(8'h48, 1'b0);
        send(8'h49, 1'b0);
        send(8'h0A, 1'b0);
        wait_idle("nl");
        chk("nl_writes", hist.size() - h0, 5);
        chk("nl_w0", hist[h0].data, 32'h48492020);
        chk("nl_w3", hist[h0+3].data, 32'h20202020);
        chk("nl_cmd", {hist[h0+4].data[30:0], hist[h0+4].sel}, {31'h000000C0, 1'b0});
        check_cursor("nl");
        s0 = strobes;
        send(8'h0A, 1'b0);
        wait_idle("nl2");
        chk("nl2_no_write", strobes, s0);
        check_cursor("nl2");

        // Flush pads only to the word boundary; an empty flush is dropped
        do_reset();
        h0 = hist.size();
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send_flush();
        wait_idle("flush");
        chk("flush_word", hist[h0].data, 32'h41422020);
        chk("flush_col", cursor_col, 4'd4);
        s0 = strobes;
        send_flush();
        wait_idle("flush_empty");
        chk("flush_empty_no_write", strobes, s0);

        // Randomised stream of characters, newlines and flushes
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(99, 0);
            if (r < 8) begin
                send(8'h0A, 1'b0);
            end else if (r < 15) begin
                send_flush();
            end else begin
                c = 8'($urandom_range(126, 33));
                send(c, ($urandom_range(9, 0) == 0));
            end
        end
        wait_idle("random");
        check_cursor("random");

        // Driver never answers: timeout_err after TO cycles, next word still goes out
        do_reset();
        tie_high = 1'b1;
        chk("to_before", timeout_err, 1'b0);
        s = "TIME";
        for (int i = 0; i < 4; i++) send(s[i], 1'b0);
        wait_strobe("to");
        n = 0;
        while (!timeout_err && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency_ok", (n >= TO && n <= TO + 1), 1'b1);
        chk("to_set", timeout_err, 1'b1);
        tie_high = 1'b0;
        s0 = strobes;
        s = "NEXT";
        for (int i = 0; i < 4; i++) send(s[i], 1'b0);
        wait_idle("to_next");
        chk("to_next_issued", strobes, s0 + 1);
        chk("to_sticky", timeout_err, 1'b1);
        check_cursor("to");

        // Reset asserted during the strobe cycle
        do_reset();
        s = "WXYZ";
        for (int i = 0; i < 4; i++) send(s[i], 1'b0);
        wait_strobe("rst_strobe");
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_strobe", bus.lcd_enable_writing, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_idle("rst_strobe_recover");

        // Reset asserted while waiting for the driver to finish
        drv_min = 6;
        drv_max = 6;
        s = "WXYZ";
        for (int i = 0; i < 4; i++) send(s[i], 1'b0);
        wait_strobe("rst_wd");
        @(negedge clk);
        @(negedge clk);
        chk("rst_wd_busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_wd_strobe", bus.lcd_enable_writing, 1'b0);
        chk("rst_wd_data", bus.lcd_data, 32'h0);
        chk("rst_wd_busy", busy, 1'b0);
        chk("rst_wd_col", cursor_col, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drv_min = 1;
        drv_max = 4;
        h0 = hist.size();
        send(8'h58, 1'b0);
        send_flush();
        wait_idle("rst_x");
        chk("rst_x_word", hist[h0].data, 32'h58202020);
        chk("rst_x_col", cursor_col, 4'd4);
        check_cursor("rst_x");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
